fifo_umbral: RTL and testbench
==============================

Name: fifo_umbral

Overview:
Synchronous FIFO with programmable almost-full/almost-empty thresholds. One instance backs each queue of the QoS datapath: the main FIFO, the VC0/VC1 FIFOs and the D0/D1 FIFOs. Its threshold inputs are driven by the condition state machine. Its empty and error outputs are concatenated to form that state machine's FIFO_EMPTIES / FIFO_ERRORS buses, and its almost_full output back-pressures the upstream arbiter.

Parameters:
DATA_W, 10, width of a stored word.
ADDR_W, 2, address bits; depth = 2**ADDR_W = 4 words.
UMBRAL_W, 4, width of the threshold inputs (4 for main/D FIFOs, 16 for VC FIFOs).

Ports:
clk  in  1  single clock; all state on posedge.
reset_L  in  1  asynchronous, active-low reset.
wr_en  in  1  push data_in this cycle.
data_in  in  DATA_W  write data.
rd_en  in  1  pop one word this cycle.
umbral_high  in  UMBRAL_W  almost-full threshold (word count).
umbral_low  in  UMBRAL_W  almost-empty threshold (word count).
data_out  out  DATA_W  registered read data.
valid_out  out  1  data_out holds a word popped on the previous cycle.
fifo_empty  out  1  count == 0.
fifo_full  out  1  count == 2**ADDR_W.
almost_full  out  1  count >= umbral_high.
almost_empty  out  1  count <= umbral_low.
fifo_error  out  1  sticky overflow/underflow flag.
count  out  ADDR_W+1  current occupancy, 0 to 2**ADDR_W.

Behaviour:
- Reset (reset_L=0, asynchronous): clears all state regardless of clk.
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, valid_out = 0, fifo_error = 0.
  - Flags follow from count = 0: fifo_empty = 1, fifo_full = 0, almost_empty = 1 if umbral_low >= 0 (always true, so 1), almost_full = 1 only if umbral_high == 0.
  - Storage RAM contents are not reset.
- Reset released mid-traffic: the first edge after deassertion is a normal cycle with empty state.
- Write: on posedge with wr_en=1 and (not full, or rd_en=1 with a legal read):
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments and wraps from 2**ADDR_W-1 to 0.
- Read: on posedge with rd_en=1 and not empty:
  - data_out <= mem[rd_ptr]; valid_out <= 1.
  - rd_ptr increments with the same wrap.
  - Latency: the word is visible one cycle after rd_en.
- Idle read cycle: valid_out <= 0; data_out holds its last value.
- Count update: count <= count + legal_write - legal_read.
- Simultaneous wr_en and rd_en:
  - Full: both legal; count unchanged; no overflow.
  - Empty: write legal, read is an underflow; no bypass, so the written word is readable from the next cycle.
  - Otherwise: both legal; count unchanged.
- Overflow: wr_en=1, full, rd_en=0. Write dropped; pointers unchanged; fifo_error <= 1.
- Underflow: rd_en=1, empty. No pop; valid_out <= 0; fifo_error <= 1.
- fifo_error is sticky until reset_L=0; traffic continues normally after it is set. The condition state machine latches it into its ERROR state.
- Threshold flags:
  - fifo_empty, fifo_full, almost_full and almost_empty are combinational from the count register and the current threshold inputs.
  - Comparisons are unsigned. count is zero-extended to max(ADDR_W+1, UMBRAL_W) bits.
  - Threshold changes take effect the same cycle; no sampling.
  - While the state machine holds thresholds at 0 (reset/INIT): almost_full = 1 and almost_empty = fifo_empty.
  - umbral_high greater than depth means almost_full never asserts; umbral_low >= depth means almost_empty is always 1.

Decomposition:
- Shared package qos_pkg holds:
  - Default widths: MF/D UMBRAL_W = 4, VC UMBRAL_W = 16, DATA_W = 10, ADDR_W = 2.
  - FIFO index constants for the 5-bit empty/error buses: MF=4, VC0=3, VC1=2, D0=1, D1=0.
- Sub-module: memoria_dp. A DATA_W x 2**ADDR_W register array with one synchronous write port and a combinational read port, not reset. Pointer/count/flag logic stays in fifo_umbral.

Test Plan:
1. Reset then fill. Hold reset_L=0 mid-cycle, then release. Write 0x101, 0x102, 0x103, 0x104 on consecutive cycles.
   -> count goes 1, 2, 3, 4; fifo_full = 1 after the 4th write; fifo_empty = 0 after the 1st write; fifo_error = 0.
2. Drain and latency. From full, assert rd_en for 4 cycles.
   -> data_out = 0x101..0x104, each one cycle after its rd_en, with valid_out = 1; then fifo_empty = 1 and count = 0.
3. Overflow. With the FIFO full and rd_en=0, write 0x3FF.
   -> write dropped; count stays 4; fifo_error = 1 from the next cycle and stays set. A subsequent drain returns the original 4 words.
4. Underflow with simultaneous write. On an empty FIFO, assert rd_en=1 and wr_en=1 with data 0x055.
   -> fifo_error = 1, valid_out = 0, count = 1. The next read returns 0x055.
5. Full plus simultaneous read/write. While full, assert rd_en=1 and wr_en=1 with data 0x2AA for 6 cycles.
   -> count stays 4; no error; pointers wrap; the words read are in FIFO order and 0x2AA appears after the prior contents.
6. Thresholds. Set umbral_high=3, umbral_low=1; write 3 words, then read 2.
   -> almost_full rises when count = 3 and falls when count = 2; almost_empty = 1 at count ≤ 1. With umbral_high=0: almost_full = 1 at count = 0. Asserting reset mid-sequence clears fifo_error asynchronously.

Source files
------------

// File: rtl/qos_pkg.sv
// qos_pkg: shared constants for the QoS datapath FIFOs.
//   - Default widths for the main/D FIFOs and the VC FIFOs.
//   - Bit positions of each FIFO inside the 5-bit FIFO_EMPTIES /
//     FIFO_ERRORS buses seen by the condition state machine.
//   - max_int helper used to size the threshold comparators.
package qos_pkg;

  localparam int DEF_DATA_W  = 10;
  localparam int DEF_ADDR_W  = 2;
  localparam int MF_UMBRAL_W = 4;
  localparam int D_UMBRAL_W  = 4;
  localparam int VC_UMBRAL_W = 16;

  // Bit index of each FIFO in the concatenated empty/error buses.
  localparam int IDX_MF  = 4;
  localparam int IDX_VC0 = 3;
  localparam int IDX_VC1 = 2;
  localparam int IDX_D0  = 1;
  localparam int IDX_D1  = 0;

  typedef logic [4:0] fifo_bus_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memoria_dp.sv
// memoria_dp: DATA_W x 2**ADDR_W register array, one synchronous write
// port and one combinational read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module memoria_dp
  import qos_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage write port; deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full and
// almost-empty thresholds.
// Ports:
//   clk, reset_L          - clock, asynchronous active-low reset
//   wr_en, data_in        - push request and data
//   rd_en                 - pop request
//   umbral_high/low       - almost-full / almost-empty thresholds (words)
//   data_out, valid_out   - registered pop data, valid one cycle after rd_en
//   fifo_empty/full       - occupancy flags
//   almost_full/empty     - threshold flags, combinational from count
//   fifo_error            - sticky overflow/underflow flag
//   count                 - occupancy, 0 .. 2**ADDR_W
module fifo_umbral
  import qos_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int UMBRAL_W = MF_UMBRAL_W
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                rd_en,
  input  logic [UMBRAL_W-1:0] umbral_high,
  input  logic [UMBRAL_W-1:0] umbral_low,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                fifo_error,
  output logic [ADDR_W:0]     count
);

  // Comparator width: wide enough for both the count and the thresholds
  // so a threshold above the depth compares correctly.
  localparam int CMP_W = max_int(ADDR_W + 1, UMBRAL_W);

  localparam logic [ADDR_W:0]   ZERO_COUNT = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ZERO_PTR   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_PTR    = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_DATA  = {DATA_W{1'b0}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] rd_word;
  logic              is_empty;
  logic              is_full;
  logic              legal_read;
  logic              legal_write;
  logic              bad_access;
  logic [CMP_W-1:0]  count_ext;
  logic [CMP_W-1:0]  high_ext;
  logic [CMP_W-1:0]  low_ext;

  memoria_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (legal_write),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Decide which requests are honoured this cycle. A write into a full FIFO
  // is still legal when a pop frees a slot on the same edge; a read on an
  // empty FIFO never bypasses a same-cycle write.
  always_comb begin
    is_empty    = 1'b0;
    is_full     = 1'b0;
    legal_read  = 1'b0;
    legal_write = 1'b0;
    bad_access  = 1'b0;
    is_empty    = (count == ZERO_COUNT);
    is_full     = (count == FULL_COUNT);
    legal_read  = rd_en & ~is_empty;
    legal_write = wr_en & (~is_full | legal_read);
    bad_access  = (rd_en & is_empty) | (wr_en & is_full & ~rd_en);
  end

  // Status flags, combinational from count and the live thresholds.
  always_comb begin
    count_ext    = CMP_W'(count);
    high_ext     = CMP_W'(umbral_high);
    low_ext      = CMP_W'(umbral_low);
    fifo_empty   = is_empty;
    fifo_full    = is_full;
    almost_full  = (count_ext >= high_ext);
    almost_empty = (count_ext <= low_ext);
  end

  // Write pointer; wraps naturally at 2**ADDR_W.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= ZERO_PTR;
    end else if (legal_write) begin
      wr_ptr <= wr_ptr + ONE_PTR;
    end
  end

  // Read pointer and registered read data; data_out holds on idle cycles.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr    <= ZERO_PTR;
      data_out  <= ZERO_DATA;
      valid_out <= 1'b0;
    end else if (legal_read) begin
      rd_ptr    <= rd_ptr + ONE_PTR;
      data_out  <= rd_word;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count <= ZERO_COUNT;
    end else begin
      case ({legal_write, legal_read})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // Sticky error: only reset clears it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_error <= 1'b0;
    end else if (bad_access) begin
      fifo_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed bench for fifo_umbral with a queue-based model
// and a negedge compare process, plus hand-computed literal checks.
module tb_fifo_umbral;

  localparam int DW = 10;
  localparam int AW = 2;
  localparam int UW = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = 10'h000;
  logic          rd_en = 1'b0;
  logic [UW-1:0] umbral_high = 4'd0;
  logic [UW-1:0] umbral_low = 4'd0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          almost_full;
  logic          almost_empty;
  logic          fifo_error;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Behavioural model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout = 10'h000;
  bit            m_valid = 1'b0;
  bit            m_err = 1'b0;

  fifo_umbral #(.DATA_W(DW), .ADDR_W(AW), .UMBRAL_W(UW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .umbral_high  (umbral_high),
    .umbral_low   (umbral_low),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One edge of the model, from the rules: pop if non-empty, push if room
  // (room includes the slot freed by a same-cycle pop), error on bad access.
  task automatic model_step();
    int  sz;
    bit  rd_ok;
    bit  wr_ok;
    sz    = m_q.size();
    rd_ok = rd_en && (sz > 0);
    wr_ok = wr_en && ((sz < DEPTH) || rd_ok);
    if ((rd_en && sz == 0) || (wr_en && sz == DEPTH && !rd_en)) m_err = 1'b1;
    if (rd_ok) begin
      m_dout  = m_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr_ok) m_q.push_back(data_in);
  endtask

  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    model_step();
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reset asserted away from any edge; error must clear without a clock.
  task automatic do_reset();
    reset_L = 1'b0;
    m_q.delete();
    m_dout  = 10'h000;
    m_valid = 1'b0;
    m_err   = 1'b0;
    #1;
    check("async_reset_error", int'(fifo_error), 0);
    check("async_reset_count", int'(count), 0);
    @(negedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  // Compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_count", int'(count), m_q.size());
      check("m_empty", int'(fifo_empty), int'(m_q.size() == 0));
      check("m_full", int'(fifo_full), int'(m_q.size() == DEPTH));
      check("m_almost_full", int'(almost_full), int'(m_q.size() >= int'(umbral_high)));
      check("m_almost_empty", int'(almost_empty), int'(m_q.size() <= int'(umbral_low)));
      check("m_error", int'(fifo_error), int'(m_err));
      check("m_valid", int'(valid_out), int'(m_valid));
      check("m_data_out", int'(data_out), int'(m_dout));
    end
  end

  logic [DW-1:0] exp5 [6];

  initial begin
    exp5[0] = 10'h301; exp5[1] = 10'h302; exp5[2] = 10'h303;
    exp5[3] = 10'h304; exp5[4] = 10'h2AA; exp5[5] = 10'h2AA;

    // Reset state with thresholds held at 0
    #2;
    reset_L = 1'b0;
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_almost_full", int'(almost_full), 1);
    check("rst_almost_empty", int'(almost_empty), 1);
    check("rst_error", int'(fifo_error), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    #2;
    reset_L = 1'b1;
    umbral_high = 4'd4;
    umbral_low  = 4'd0;

    // 1. Fill
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 10'h101 + 10'(i), 1'b0);
      check("fill_count", int'(count), i + 1);
      check("fill_empty", int'(fifo_empty), 0);
    end
    check("fill_full", int'(fifo_full), 1);
    check("fill_error", int'(fifo_error), 0);

    // 2. Drain, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 10'h000, 1'b1);
      check("drain_valid", int'(valid_out), 1);
      check("drain_data", int'(data_out), 'h101 + i);
    end
    check("drain_empty", int'(fifo_empty), 1);
    check("drain_count", int'(count), 0);
    cycle(1'b0, 10'h000, 1'b0);
    check("idle_valid", int'(valid_out), 0);
    check("idle_hold", int'(data_out), 'h104);

    // 3. Overflow
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'h201 + 10'(i), 1'b0);
    cycle(1'b1, 10'h3FF, 1'b0);
    check("ovf_count", int'(count), 4);
    check("ovf_error", int'(fifo_error), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 10'h000, 1'b1);
      check("ovf_drain", int'(data_out), 'h201 + i);
      check("ovf_sticky", int'(fifo_error), 1);
    end

    // 4. Underflow with simultaneous write
    do_reset();
    cycle(1'b1, 10'h055, 1'b1);
    check("unf_error", int'(fifo_error), 1);
    check("unf_valid", int'(valid_out), 0);
    check("unf_count", int'(count), 1);
    cycle(1'b0, 10'h000, 1'b1);
    check("unf_read", int'(data_out), 'h055);
    check("unf_read_valid", int'(valid_out), 1);

    // 5. Full with simultaneous read/write, pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'h301 + 10'(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 10'h2AA, 1'b1);
      check("rw_full_count", int'(count), 4);
      check("rw_full_data", int'(data_out), int'(exp5[i]));
      check("rw_full_error", int'(fifo_error), 0);
    end

    // 6. Thresholds
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'h000, 1'b1);
    check("thr_drained", int'(count), 0);
    umbral_high = 4'd0;
    #1;
    check("thr_high0_af", int'(almost_full), 1);
    umbral_high = 4'd3;
    umbral_low  = 4'd1;
    #1;
    check("thr_c0_af", int'(almost_full), 0);
    cycle(1'b1, 10'h011, 1'b0);
    check("thr_c1_ae", int'(almost_empty), 1);
    cycle(1'b1, 10'h012, 1'b0);
    check("thr_c2_ae", int'(almost_empty), 0);
    check("thr_c2_af", int'(almost_full), 0);
    cycle(1'b1, 10'h013, 1'b0);
    check("thr_c3_af", int'(almost_full), 1);
    cycle(1'b0, 10'h000, 1'b1);
    check("thr_rd_c2_af", int'(almost_full), 0);
    cycle(1'b0, 10'h000, 1'b1);
    check("thr_rd_c1_ae", int'(almost_empty), 1);
    umbral_high = 4'd5;
    umbral_low  = 4'd4;
    for (int i = 0; i < 3; i++) cycle(1'b1, 10'h020 + 10'(i), 1'b0);
    check("thr_hi_gt_depth", int'(almost_full), 0);
    check("thr_lo_ge_depth", int'(almost_empty), 1);
    cycle(1'b1, 10'h3FF, 1'b0);
    check("thr_ovf_error", int'(fifo_error), 1);
    do_reset();
    cycle(1'b0, 10'h000, 1'b0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
